// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - flit type codes and header field layout shared by the network interface
package ni_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    localparam int ADDR_W       = 4;
    localparam int LEN_W        = 4;
    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_SRC_LSB  = 4;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_W        = 12;

    // Address nibbles use the router's dest_addr layout: x in [1:0], y in [3:2].
    function automatic logic [HDR_W-1:0] build_header(
        input logic [ADDR_W-1:0] dest,
        input logic [ADDR_W-1:0] src,
        input logic [LEN_W-1:0]  len
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_DEST_LSB +: ADDR_W] = dest;
        h[HDR_SRC_LSB  +: ADDR_W] = src;
        h[HDR_LEN_LSB  +: LEN_W]  = len;
        return h;
    endfunction

endpackage

// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - turns a message plus data words into HEAD/BODY/TAIL flits for the local router port
// Optional packet counter output pkt_cnt enabled by defining NI_PKT_CNT_EN.
module ni_packetizer
    import ni_pkg::*;
#(
    parameter int              NOC_WIDTH  = 4,
    parameter int              NOC_LENGTH = 4,
    parameter logic [3:0]      ROUTER_ID  = 4'b0000,
    parameter int              DATA_W     = 32,
    parameter int              MAX_LEN    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [3:0]        msg_dest,
    input  logic [3:0]        msg_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [DATA_W+1:0] flit_out,
    output logic              busy,
    output logic              err_len
`ifdef NI_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAD = 2'b01,
        S_DATA = 2'b10
    } state_e;

    localparam logic [LEN_W:0] MAX_LEN_L = (LEN_W+1)'(MAX_LEN);

    // Two-bit address axes cap the mesh at 4x4; larger meshes or narrow payloads cannot carry the header.
    if (NOC_WIDTH > 4 || NOC_LENGTH > 4 || DATA_W < HDR_W) begin : g_cfg_unsupported
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_dest;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_err_len;
    logic               w_accept;
    logic               w_len_ok;
    logic               w_is_tail;
    logic               w_xfer;
    logic [DATA_W-1:0]  w_head_payload;

    assign w_accept       = (r_state == S_IDLE) && msg_valid;
    assign w_len_ok       = (msg_len != '0) && ({1'b0, msg_len} <= MAX_LEN_L);
    assign w_is_tail      = (r_cnt == r_len - 4'd1);
    assign w_xfer         = (r_state == S_DATA) && data_valid && flit_ready;
    assign w_head_payload = DATA_W'(build_header(r_dest, ROUTER_ID, r_len));
    assign err_len        = r_err_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dest    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err_len <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_len <= w_accept && !w_len_ok;
            if (w_accept) begin
                r_dest <= msg_dest;
                r_len  <= msg_len;
            end
            if (r_state == S_HEAD && flit_ready) begin
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        msg_ready   = 1'b0;
        data_ready  = 1'b0;
        flit_valid  = 1'b0;
        flit_out    = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid && w_len_ok) begin
                    w_state_nxt = S_HEAD;
                end
            end
            S_HEAD: begin
                busy       = 1'b1;
                flit_valid = 1'b1;
                flit_out   = {FLIT_HEAD, w_head_payload};
                if (flit_ready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                flit_valid = data_valid;
                data_ready = flit_ready;
                flit_out   = {(w_is_tail ? FLIT_TAIL : FLIT_BODY), data_in};
                if (w_xfer && w_is_tail) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef NI_PKT_CNT_EN
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_xfer && w_is_tail) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: doc/ni_packetizer.md
NI_PACKETIZER -- requirements
Module: ni_packetizer

Interface
- REQ-001 SHALL have parameter NOC_WIDTH, default 4: mesh columns.
- REQ-002 SHALL have parameter NOC_LENGTH, default 4: mesh rows.
- REQ-003 SHALL have parameter ROUTER_ID, default 4'b0000: own address, x in bits [1:0], y in bits [3:2].
- REQ-004 SHALL have parameter DATA_W, default 32: payload width.
- REQ-005 SHALL have parameter MAX_LEN, default 8: maximum data words per packet.
- REQ-006 SHALL have one clock and an asynchronous, active-low reset, on these ports:
  - clk  in  1  clock.
  - rst_n  in  1  reset.
- REQ-007 SHALL have these message ports:
  - msg_valid  in  1  message request.
  - msg_ready  out  1  message accept.
  - msg_dest  in  4  destination address, x in bits [1:0], y in bits [3:2].
  - msg_len  in  4  number of data words.
- REQ-008 SHALL have these data ports:
  - data_valid  in  1  data word valid.
  - data_ready  out  1  data word accepted.
  - data_in  in  DATA_W  data word.
- REQ-009 SHALL have these flit ports, to the router local (L) input:
  - flit_valid  out  1  flit valid.
  - flit_ready  in  1  flit accept.
  - flit_out  out  DATA_W+2  flit; bits [DATA_W+1:DATA_W] are the flit type.
- REQ-010 SHALL have these status ports:
  - busy  out  1  packet in progress.
  - err_len  out  1  one-cycle pulse: message dropped for an illegal length.

Function
- REQ-011 SHALL use these flit type codes: HEAD=2'b01, BODY=2'b10, TAIL=2'b11.
- REQ-012 SHALL implement FSM states IDLE, HEAD and DATA.
- REQ-013 SHALL drive msg_ready=1 only in IDLE.
- REQ-014 In IDLE, on msg_valid&&msg_ready, SHALL register dest and len.
  - If len is 0 or greater than MAX_LEN: pulse err_len for the next cycle and stay in IDLE.
  - Otherwise: go to HEAD.
- REQ-015 In HEAD, SHALL drive flit_valid=1 and flit_out={HEAD, payload}.
  - payload[3:0] = dest, [7:4] = ROUTER_ID, [11:8] = len, all other bits 0.
  - On flit_ready, go to DATA with word counter cnt=0.
- REQ-016 In DATA, SHALL drive flit_valid=data_valid, data_ready=flit_ready and flit_out={type, data_in}.
  - type = TAIL when cnt==len-1, else BODY.
- REQ-017 SHALL count a transfer as data_valid&&flit_ready in DATA, and on each transfer increment cnt.
  - A transfer on the TAIL flit returns the FSM to IDLE.
- REQ-018 The head flit SHALL be valid in the cycle after message acceptance (1-cycle latency).
  - A new message is acceptable in the cycle after the tail transfer.
- REQ-019 Once flit_valid is asserted in HEAD, flit_out SHALL hold stable until flit_ready.
- REQ-020 SHALL hold data_ready=0 outside DATA, and flit_valid=0 in IDLE.
- REQ-021 SHALL assert busy in HEAD and DATA.
- REQ-022 SHALL treat dest==ROUTER_ID as legal; the router delivers such packets to its L port.
- REQ-023 SHALL not range-check dest against NOC_WIDTH/NOC_LENGTH.
- REQ-024 With len==1, the single data flit SHALL be TAIL, with no BODY flit.

Reset
- REQ-025 rst_n low SHALL immediately force the FSM to IDLE and clear cnt, dest, len and err_len to 0.
- REQ-026 Reset outputs SHALL be: flit_valid=0, data_ready=0, busy=0, err_len=0, msg_ready=1 and flit_out=0.
- REQ-027 A reset mid-packet SHALL abandon the packet; no tail flit is emitted.

Configuration
- REQ-028 With NI_PKT_CNT_EN defined, SHALL add output pkt_cnt[15:0].
  - pkt_cnt increments on each tail transfer, wraps 16'hFFFF->0 and resets to 0.
- REQ-029 Without NI_PKT_CNT_EN, SHALL not have port pkt_cnt and SHALL not have its register.

Structure
- REQ-030 Shared package ni_pkg SHALL hold:
  - the flit type enum (HEAD/BODY/TAIL);
  - the header field position constants;
  - a function building the header payload from dest, src and len.
- REQ-031 The address field layout SHALL match the Routing_Unit dest_addr encoding.
- REQ-032 SHALL contain no sub-module; the FSM and counter are in ni_packetizer.

Verification (ROUTER_ID=4'b1001, DATA_W=32, MAX_LEN=8)
- REQ-033 Message dest=4'b0110, len=3, words A,B,C, flit_ready=1:
  - required flits, one per cycle: HEAD with payload 0x396, then BODY A, BODY B, TAIL C;
  - busy falls after the TAIL flit.
- REQ-034 len=1, word 0xDEADBEEF: required flits are HEAD then TAIL 0xDEADBEEF, with no BODY flit.
- REQ-035 len=0, then separately len=9:
  - required: err_len pulses 1 cycle, no flit is emitted, and msg_ready stays 1.
- REQ-036 flit_ready held 0 for 3 cycles during HEAD, then data_valid gaps during DATA:
  - required: flit_out stable while stalled, and no word is lost or duplicated.
- REQ-037 rst_n asserted after the 2nd of 4 words:
  - required: flit_valid=0 immediately, and the next message starts with a fresh HEAD;
  - with NI_PKT_CNT_EN, pkt_cnt=0.
